// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_AW       = 8;
  localparam int unsigned DEF_DW       = 8;
  localparam int unsigned DEF_MAX_WAIT = 4;

  // Which requester a returning read belongs to.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  // One requester's request bundle at the default widths.
  typedef struct packed {
    logic              req;
    logic              we;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] wdata;
  } req_bundle_t;

endpackage

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Saturating DMA wait counter with a registered starvation flag.
module dmem_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic dma_starved
);

  localparam int unsigned    CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_next;

  // Count refused DMA cycles; any grant or dropped request starts over.
  always_comb begin
    cnt_next = wait_cnt;
    if (!dma_req || dma_gnt) begin
      cnt_next = '0;
    end else if (wait_cnt != CNT_MAX) begin
      cnt_next = wait_cnt + 1'b1;
    end
  end

  // The flag is registered from the next count so that it is high exactly
  // while wait_cnt >= MAX_WAIT, letting DMA win on the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      dma_starved <= 1'b0;
    end else begin
      wait_cnt    <= cnt_next;
      dma_starved <= (cnt_next >= CNT_MAX);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// CPU/DMA arbiter for the single-port data memory. Fixed CPU priority with a
// starvation override for DMA; read data is steered back to the grant owner
// one cycle later. Define DMEM_ARB_STATS_EN to add grant/conflict counters.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          dma_starved
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_cpu_grants,
  output logic [15:0]   stat_dma_grants,
  output logic [15:0]   stat_conflicts
`endif
);

  // Request bundle at this instance's widths (mirrors req_bundle_t).
  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } port_req_t;

  port_req_t cpu_bus;
  port_req_t dma_bus;
  logic      rd_pend;
  owner_t    rd_owner;

  // Gather each requester's inputs into a bundle.
  always_comb begin
    cpu_bus = '{req: cpu_req, we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    dma_bus = '{req: dma_req, we: dma_we, addr: dma_addr, wdata: dma_wdata};
  end

  // CPU wins ties unless DMA has been refused long enough; nothing is
  // granted while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (dma_bus.req && (!cpu_bus.req || dma_starved)) begin
        dma_gnt = 1'b1;
      end else if (cpu_bus.req) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  // Drive the memory port from the winner; buses idle at zero.
  always_comb begin
    mem_en    = cpu_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dma_gnt) begin
      mem_we    = dma_bus.we;
      mem_addr  = dma_bus.addr;
      mem_wdata = dma_bus.wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_bus.we;
      mem_addr  = cpu_bus.addr;
      mem_wdata = cpu_bus.wdata;
    end
  end

  // Remember whether last cycle issued a read, and for whom.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_CPU;
    end else begin
      rd_pend <= mem_en & ~mem_we;
      if (mem_en) begin
        rd_owner <= dma_gnt ? OWN_DMA : OWN_CPU;
      end
    end
  end

  // Steer returning read data to its owner only.
  always_comb begin
    cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
    dma_rvalid = rd_pend && (rd_owner == OWN_DMA);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dma_rdata  = dma_rvalid ? mem_rdata : '0;
  end

  dmem_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .dma_req    (dma_req),
    .dma_gnt    (dma_gnt),
    .dma_starved(dma_starved)
  );

`ifdef DMEM_ARB_STATS_EN
  // Saturating activity counters for grants and contended cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cpu_grants <= '0;
      stat_dma_grants <= '0;
      stat_conflicts  <= '0;
    end else begin
      if (cpu_gnt && (stat_cpu_grants != '1)) begin
        stat_cpu_grants <= stat_cpu_grants + 16'd1;
      end
      if (dma_gnt && (stat_dma_grants != '1)) begin
        stat_dma_grants <= stat_dma_grants + 16'd1;
      end
      if (cpu_req && dma_req && (stat_conflicts != '1)) begin
        stat_conflicts <= stat_conflicts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port 8-bit data memory between two requesters: the core's load/store path (CPU) and a DMA/preload engine that fills and inspects memory around program runs.
- Sits between the load/store path, the DMA engine and the data memory instance inside top_level.
- Fixed priority to the CPU, plus an anti-starvation counter that forces a DMA grant after a bounded wait.
- Read data returns one cycle after grant and is steered to the owner of that grant.

Parameters:
- AW, 8, address width in bits (memory depth is 2**AW bytes).
- DW, 8, data width in bits.
- MAX_WAIT, 4, consecutive cycles DMA may be refused before it wins priority (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  CPU write enable (1 = store)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU store data
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DW  CPU read data
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  DMA equivalents of the CPU inputs
- dma_gnt, dma_rvalid, dma_rdata  out  1/1/DW  DMA equivalents of the CPU outputs
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after a read strobe
- dma_starved  out  1  registered; high while the wait counter is ≥ MAX_WAIT

Behaviour:
- Reset (async, active-high): wait_cnt=0, rvalid pipeline=0, owner=CPU, dma_starved=0. All gnt/rvalid outputs low; mem_en=0, mem_we=0; address and data buses 0.
- Arbitration is combinational within the request cycle:
  - Only one req high: that requester is granted.
  - Both high, dma_starved=0: CPU granted.
  - Both high, dma_starved=1: DMA granted.
  - At most one gnt is high per cycle.
- On a grant: mem_en=1; mem_we/mem_addr/mem_wdata are muxed from the winner in the same cycle. With no grant: mem_en=0, mem_we=0, buses 0.
- Requesters hold req/we/addr/wdata stable until gnt. Deasserting req before gnt cancels the request, and a cancelled request is never granted.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each cycle dma_req=1 and dma_gnt=0.
  - Clears on dma_gnt, or when dma_req=0.
  - dma_starved = (wait_cnt ≥ MAX_WAIT), registered.
- Read return:
  - A granted read (we=0) sets rd_pend and rd_owner on the next edge.
  - In the following cycle, that owner's rvalid=1 and its rdata=mem_rdata. The other requester sees rvalid=0 and rdata=0.
  - Writes produce no rvalid.
- Pipelining: back-to-back grants on consecutive cycles are allowed, giving one access per cycle. A read return and a new grant may coincide.
- Throughput: a steady CPU stream yields to DMA within MAX_WAIT+1 cycles.
- Reset mid-read: the pending rvalid is dropped and no late rvalid appears after reset release.

Optional Feature:
- DMEM_ARB_STATS_EN defined adds three 16-bit saturating counters:
  - stat_cpu_grants, stat_dma_grants, stat_conflicts (cycles with both req high).
  - Cleared by reset.
  - Exposed as extra output ports of the same names.
- Undefined: no counters and no extra ports. Arbitration behaviour is identical either way.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - typedef enum logic {OWN_CPU, OWN_DMA} owner_t
  - default constants for AW, DW, MAX_WAIT
  - typedef struct for a requester bundle {req, we, addr, wdata}
- One natural sub-module, dmem_starve_ctr: saturating wait counter plus the registered dma_starved flag.

Test Plan:
- CPU-only: preload core[3]=8'hC3; CPU read addr 3 → cpu_gnt same cycle, next cycle cpu_rvalid=1 with cpu_rdata=8'hC3; dma_rvalid stays 0.
- DMA write then CPU read: DMA writes 8'h55 to addr 4; CPU then reads addr 4 → cpu_rdata=8'h55; mem_we=1 only in the write cycle.
- Conflict: both request in the same cycle → cpu_gnt=1, dma_gnt=0, dma_req held; DMA granted once CPU req drops.
- Starvation, MAX_WAIT=4: CPU requests every cycle with DMA requesting → dma_starved rises after 4 refused cycles; dma_gnt on the next cycle, counter returns to 0.
- Back-to-back: CPU reads addr 0,1,2 on consecutive cycles with core={F0,CC,3C} → rvalid high three consecutive cycles with data F0, CC, 3C in order.
- Reset mid-read: assert reset in the cycle after a read grant → no rvalid on any port; all outputs at reset values until the next grant.
